spi_cmd_regfile: RTL
====================

// Module: spi_cmd_regfile
// PURPOSE
//  Byte-level command decoder and register file downstream of spi_slave.
//  - Consumes received bytes, decodes a 2-byte read/write protocol, holds control registers.
//  - Drives the board LED through an internal blink generator.
//  - Returns read data to spi_slave as a TX preload byte.
// PARAMETERS
//  CLK_HZ       50_000_000  i_clk frequency; sets the 1 ms tick prescaler (CLK_HZ/1000 cycles).
//  ID_VALUE     8'hA5       Constant returned by register 0x00.
//  DIV_RESET    16'd500     Reset value of the blink half-period, in ms.
// PORTS
//  i_clk        in   1   System clock, 50 MHz.
//  i_rst_n      in   1   Asynchronous reset, active-low.
//  i_cs_n       in   1   Synchronized chip select from spi_slave; high = frame boundary.
//  i_rx_valid   in   1   One-cycle strobe: i_rx_byte holds a new byte.
//  i_rx_byte    in   8   Received byte, MSB first as assembled by spi_slave.
//  o_tx_load    out  1   One-cycle strobe: spi_slave must preload o_tx_byte.
//  o_tx_byte    out  8   Byte to shift out on MISO during the next SPI byte.
//  o_led        out  1   LED drive.
//  o_err        out  1   Copy of STATUS.err (sticky).
// BEHAVIOUR
//  Reset (async, all outputs): o_tx_load=0, o_tx_byte=0, o_led=0, o_err=0.
//  Reset (registers): CTRL=0x03, DIV=DIV_RESET, SCRATCH=0, STATUS=0.
//  Register map:
//   0x00 ID (RO)
//   0x01 CTRL (RW): [0]=led_en, [1]=blink_en, [2]=led_manual
//   0x02 DIV_L (RW)
//   0x03 DIV_H (RW)
//   0x04 STATUS (RO): [0]=err sticky, [7:4]=frame count mod 16
//   0x05 SCRATCH (RW)
//   0x06-0x7F: read 0x00, write ignored and sets err.
//  Protocol: byte0 = {rw, addr[6:0]} (rw=1 read); following bytes carry data.
//  FSM states: IDLE, DATA.
//   - IDLE + i_rx_valid: latch rw and addr, go to DATA.
//   - If rw=1: o_tx_load pulses exactly 1 cycle after the strobe; o_tx_byte = reg[addr].
//   - DATA + i_rx_valid, rw=0: write the byte to reg[addr] the cycle after the strobe.
//     Write to a RO address: no change, err set.
//   - DATA + i_rx_valid, rw=1: the received byte is ignored (dummy).
//   - Additional data bytes in DATA use addr as updated per CONFIGURATION.
//  Frame end: i_cs_n high in any state -> IDLE next cycle. Partial frame discarded.
//   - STATUS frame count increments on each i_cs_n 0->1 edge seen while in DATA; wraps 15->0.
//  i_rx_valid while i_cs_n=1: ignored.
//  i_rx_valid in the same cycle as i_cs_n rising: cs wins; byte discarded, no write.
//  STATUS.err: write 1 to STATUS bit0 clears it. Any set event in the same cycle wins over the clear.
//  Blink generator:
//   - Prescaler counts 0..CLK_HZ/1000-1 and emits a 1 ms tick.
//   - A 16-bit ms counter toggles the blink bit when it reaches DIV, then resets to 0.
//   - DIV=0 is treated as 1.
//   - A write to DIV_L or DIV_H clears the ms counter.
//  LED output:
//   - o_led = led_en & (blink_en ? blink : led_manual).
//   - o_led is registered: 1 cycle after CTRL or blink changes.
// CONFIGURATION
//  SPI_CMD_AUTOINC_EN defined:
//   - In DATA, addr increments after every data byte and wraps 0x7F->0x00.
//   - For reads, each data-byte strobe triggers another o_tx_load with reg[addr+1].
//  SPI_CMD_AUTOINC_EN undefined:
//   - addr is fixed for the frame; extra write bytes rewrite the same register.
//   - Extra read bytes reload the same value.
// TESTING
//  1. Release reset, idle 100 cycles -> o_led=0, o_err=0; after the first blink half-period, o_led toggles (CTRL=0x03).
//  2. Frame {0x80} -> o_tx_load pulse 1 cycle later with o_tx_byte=0xA5.
//  3. Frame {0x05,0x3C} then frame {0x85,dummy} -> second frame loads o_tx_byte=0x3C.
//  4. Frame {0x01,0x05} -> o_led=1 steady; then {0x01,0x00} -> o_led=0 within 2 cycles.
//  5. Frame {0x00,0x12} -> ID unchanged, o_err=1; then {0x04,0x01} -> o_err=0.
//     Frame count field advances by 1 per frame.
//  6. Frame {0x05} then CS high mid-byte, followed by a strobe coincident with CS rise -> SCRATCH unchanged, FSM in IDLE.
//     With AUTOINC: {0x02,0xE8,0x03} -> DIV=1000.

Source files
------------

// File: rtl/spi_cmd_regfile.sv
// spi_cmd_regfile
//   Byte-level command decoder and control register file that sits behind
//   spi_slave. Frames are {rw, addr[6:0]} followed by data bytes; reads
//   return data through a one-cycle TX preload strobe. Also contains the
//   LED blink generator driven by a 1 ms tick.
//
// Optional feature macro: SPI_CMD_AUTOINC_EN
//   defined   : address auto-increments after each data byte (wraps 0x7F->0x00)
//   undefined : address is fixed for the whole frame
//
// Ports
//   i_clk       system clock
//   i_rst_n     asynchronous active-low reset
//   i_cs_n      synchronized chip select (high = frame boundary)
//   i_rx_valid  one-cycle strobe, i_rx_byte holds a new byte
//   i_rx_byte   received byte
//   o_tx_load   one-cycle strobe, spi_slave preloads o_tx_byte
//   o_tx_byte   byte to shift out during the next SPI byte
//   o_led       registered LED drive
//   o_err       sticky error flag (STATUS bit 0)
module spi_cmd_regfile #(
    parameter int unsigned CLK_HZ    = 50_000_000,
    parameter logic [7:0]  ID_VALUE  = 8'hA5,
    parameter logic [15:0] DIV_RESET = 16'd500
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_cs_n,
    input  logic       i_rx_valid,
    input  logic [7:0] i_rx_byte,
    output logic       o_tx_load,
    output logic [7:0] o_tx_byte,
    output logic       o_led,
    output logic       o_err
);

    localparam int unsigned PRESC_MAX = CLK_HZ / 1000 - 1;
    localparam int unsigned PW        = (PRESC_MAX > 0) ? $clog2(PRESC_MAX + 1) : 1;

    typedef enum logic {IDLE, DATA} state_t;

    state_t      state_q, state_d;
    logic        rw_q, rw_d;
    logic [6:0]  addr_q, addr_d;
    logic        cs_q;
    logic        cs_rise;
    logic        tx_req;
    logic [6:0]  rd_addr;
    logic [7:0]  rd_data;
    logic        wr_en;
    logic        div_wr;
    logic        err_set, err_clr;

    logic [7:0]  ctrl_q;
    logic [15:0] div_q;
    logic [7:0]  scratch_q;
    logic        err_q;
    logic [3:0]  fc_q;

    logic [PW-1:0] presc_q;
    logic          tick;
    logic [15:0]   ms_q;
    logic [15:0]   div_eff;
    logic [16:0]   ms_inc;
    logic          blink_q;

    assign cs_rise = i_cs_n & ~cs_q;

    // Chip select high overrides everything, including a coincident strobe.
    always_comb begin
        state_d = state_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        tx_req  = 1'b0;
        rd_addr = addr_q;
        wr_en   = 1'b0;
        if (i_cs_n) begin
            state_d = IDLE;
        end else if (i_rx_valid) begin
            case (state_q)
                IDLE: begin
                    state_d = DATA;
                    rw_d    = i_rx_byte[7];
                    addr_d  = i_rx_byte[6:0];
                    tx_req  = i_rx_byte[7];
                    rd_addr = i_rx_byte[6:0];
                end
                DATA: begin
                    if (rw_q) begin
                        tx_req = 1'b1;
`ifdef SPI_CMD_AUTOINC_EN
                        addr_d  = addr_q + 7'd1;
                        rd_addr = addr_q + 7'd1;
`endif
                    end else begin
                        wr_en = 1'b1;
`ifdef SPI_CMD_AUTOINC_EN
                        addr_d = addr_q + 7'd1;
`endif
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        case (rd_addr)
            7'h00:   rd_data = ID_VALUE;
            7'h01:   rd_data = ctrl_q;
            7'h02:   rd_data = div_q[7:0];
            7'h03:   rd_data = div_q[15:8];
            7'h04:   rd_data = {fc_q, 3'b000, err_q};
            7'h05:   rd_data = scratch_q;
            default: rd_data = 8'h00;
        endcase
    end

    // Writes to ID or unmapped space flag an error; STATUS accepts only the clear.
    assign err_set = wr_en & ((addr_q == 7'h00) | (addr_q > 7'h05));
    assign err_clr = wr_en & (addr_q == 7'h04) & i_rx_byte[0];
    assign div_wr  = wr_en & ((addr_q == 7'h02) | (addr_q == 7'h03));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            rw_q      <= 1'b0;
            addr_q    <= '0;
            cs_q      <= 1'b1;
            o_tx_load <= 1'b0;
            o_tx_byte <= '0;
            ctrl_q    <= 8'h03;
            div_q     <= DIV_RESET;
            scratch_q <= '0;
            err_q     <= 1'b0;
            fc_q      <= '0;
        end else begin
            state_q   <= state_d;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            cs_q      <= i_cs_n;
            o_tx_load <= tx_req;
            if (tx_req)
                o_tx_byte <= rd_data;
            if (cs_rise && state_q == DATA)
                fc_q <= fc_q + 4'd1;
            if (wr_en) begin
                case (addr_q)
                    7'h01:   ctrl_q        <= i_rx_byte;
                    7'h02:   div_q[7:0]    <= i_rx_byte;
                    7'h03:   div_q[15:8]   <= i_rx_byte;
                    7'h05:   scratch_q     <= i_rx_byte;
                    default: ;
                endcase
            end
            if (err_set)
                err_q <= 1'b1;
            else if (err_clr)
                err_q <= 1'b0;
        end
    end

    assign o_err = err_q;

    assign tick    = (presc_q == PW'(PRESC_MAX));
    assign div_eff = (div_q == 16'd0) ? 16'd1 : div_q;
    assign ms_inc  = {1'b0, ms_q} + 17'd1;

    // Blink toggles every div_eff ticks, so DIV is the half-period in ms.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            presc_q <= '0;
            ms_q    <= '0;
            blink_q <= 1'b0;
            o_led   <= 1'b0;
        end else begin
            presc_q <= tick ? '0 : presc_q + PW'(1);
            if (div_wr) begin
                ms_q <= '0;
            end else if (tick) begin
                if (ms_inc >= {1'b0, div_eff}) begin
                    ms_q    <= '0;
                    blink_q <= ~blink_q;
                end else begin
                    ms_q <= ms_inc[15:0];
                end
            end
            o_led <= ctrl_q[0] & (ctrl_q[1] ? blink_q : ctrl_q[2]);
        end
    end

endmodule
